// File: rtl/af_pkg.sv
// Shared autofocus types and constants: FSM state encoding, lens range and a saturating adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package af_pkg;

  localparam int VCM_STEP_W   = 10;
  localparam int STEP_ABS_MAX = 1023;
  localparam int SHARP_W_DEF  = 24;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SETTLE,
    MEAS,
    EVAL,
    FINE_INIT,
    PARK,
    FIN
  } af_state_t;

  // All lens arithmetic is done in 11 bits. 1023 + 255 still fits, so the
  // sum never wraps before it is clamped against lim.
  function automatic logic [10:0] sat_add(input logic [10:0] a,
                                          input logic [10:0] b,
                                          input logic [10:0] lim);
    logic [10:0] s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/af_vs_edge.sv
// Frame settle counter: detects VS rising edges and pulses SETTLED on the SETTLE_FR-th edge while EN is high.
// Latency: SETTLED is combinational on the qualifying VS edge cycle; the edge detector adds one register.
// Backpressure: none; counting restarts whenever EN drops.
// Ports: CLK, RESET (sync, active-high), EN (count enable), VS (frame sync), SETTLED (done pulse).
module af_vs_edge #(
  parameter int SETTLE_FR = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic VS,
  output logic SETTLED
);

  localparam logic [7:0] LAST_EDGE = 8'(SETTLE_FR - 1);

  logic       vs_q;
  logic       vs_rise;
  logic [7:0] frame_cnt;

  // The previous VS level is tracked all the time, so an edge that lands on
  // the very first enabled cycle still counts, but edges seen while disabled
  // never accumulate.
  assign vs_rise = VS & ~vs_q;
  assign SETTLED = EN & ((SETTLE_FR == 0) | (vs_rise & (frame_cnt == LAST_EDGE)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_q      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      vs_q <= VS;
      if (!EN || SETTLED) begin
        frame_cnt <= 8'd0;
      end else if (vs_rise) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/af_sweep_ctrl.sv
// Autofocus sweep: coarse lens sweep, fine sweep around the best coarse position, then park the lens at the best.
// Latency: per position one VCM write, SETTLE_FR frames, one sharpness strobe and one EVAL cycle.
// Backpressure: VCM_REQ/VCM_STEP hold until VCM_ACK; SETTLE and MEAS wait on VS and SHARP_VALID.
// Ports: CLK, RESET (sync, active-high); START/ABORT control; VS, SHARP, SHARP_VALID from the ISP;
//        SCAL/SCAL_F coarse/fine increments; VCM_STEP/VCM_REQ/VCM_ACK to the lens driver;
//        BUSY, FINE, DONE status; BEST_STEP result.
module af_sweep_ctrl
  import af_pkg::*;
#(
  parameter int          SHARP_W   = SHARP_W_DEF,
  parameter int          SETTLE_FR = 2,
  parameter logic [10:0] STEP_MAX  = 11'h3F0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic               VS,
  input  logic [7:0]         SCAL,
  input  logic [7:0]         SCAL_F,
  input  logic [SHARP_W-1:0] SHARP,
  input  logic               SHARP_VALID,
  output logic [9:0]         VCM_STEP,
  output logic               VCM_REQ,
  input  logic               VCM_ACK,
  output logic               BUSY,
  output logic               FINE,
  output logic               DONE,
  output logic [9:0]         BEST_STEP
);

  localparam logic [10:0] ABS_MAX = 11'(STEP_ABS_MAX);

  af_state_t          state_q;
  logic [10:0]        cur_q;
  logic [10:0]        hi_q;
  logic [SHARP_W-1:0] best_val_q;
  logic [9:0]         best_step_q;
  logic [SHARP_W-1:0] sharp_q;
  logic [7:0]         scal_q;
  logic [7:0]         scal_f_q;
  logic               fine_q;
  logic               vcm_req_q;
  logic [9:0]         vcm_step_q;
  logic               busy_q;
  logic               done_q;

  logic               settled;
  logic               new_best;
  logic [9:0]         best_step_nxt;
  logic [10:0]        coarse_nxt;
  logic [10:0]        fine_nxt;
  logic [10:0]        half;
  logic [10:0]        best11;
  logic [10:0]        lo_calc;
  logic [10:0]        hi_calc;

  af_vs_edge #(
    .SETTLE_FR(SETTLE_FR)
  ) u_vs_edge (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (state_q == SETTLE),
    .VS      (VS),
    .SETTLED (settled)
  );

  // Strict compare: on a tie the earlier lens position is kept.
  assign new_best      = sharp_q > best_val_q;
  assign best_step_nxt = new_best ? cur_q[9:0] : best_step_q;

  assign coarse_nxt = sat_add(cur_q, {3'b000, scal_q}, ABS_MAX);
  assign fine_nxt   = sat_add(cur_q, {3'b000, scal_f_q}, hi_q);

  // Fine window is +/- half a coarse step around the best coarse position,
  // clamped at both ends of the lens range without going negative.
  assign half    = {4'b0000, scal_q[7:1]};
  assign best11  = {1'b0, best_step_q};
  assign lo_calc = (best11 >= half) ? (best11 - half) : 11'd0;
  assign hi_calc = sat_add(best11, half, ABS_MAX);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cur_q       <= 11'd0;
      hi_q        <= 11'd0;
      best_val_q  <= '0;
      best_step_q <= 10'd0;
      sharp_q     <= '0;
      scal_q      <= 8'd0;
      scal_f_q    <= 8'd0;
      fine_q      <= 1'b0;
      vcm_req_q   <= 1'b0;
      vcm_step_q  <= 10'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ABORT && (state_q != IDLE)) begin
        // Abandon the sweep; the best position found so far stays visible.
        state_q   <= IDLE;
        vcm_req_q <= 1'b0;
        busy_q    <= 1'b0;
        fine_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (START && !ABORT) begin
              cur_q       <= 11'd0;
              best_val_q  <= '0;
              best_step_q <= 10'd0;
              fine_q      <= 1'b0;
              scal_q      <= (SCAL == 8'd0) ? 8'd1 : SCAL;
              vcm_step_q  <= 10'd0;
              vcm_req_q   <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= MOVE;
            end
          end
          MOVE: begin
            if (VCM_ACK) begin
              vcm_req_q <= 1'b0;
              state_q   <= SETTLE;
            end
          end
          SETTLE: begin
            if (settled) begin
              state_q <= MEAS;
            end
          end
          MEAS: begin
            if (SHARP_VALID) begin
              sharp_q <= SHARP;
              state_q <= EVAL;
            end
          end
          EVAL: begin
            if (new_best) begin
              best_val_q <= sharp_q;
            end
            best_step_q <= best_step_nxt;
            if (!fine_q) begin
              if (cur_q > STEP_MAX) begin
                state_q <= FINE_INIT;
              end else begin
                cur_q      <= coarse_nxt;
                vcm_step_q <= coarse_nxt[9:0];
                vcm_req_q  <= 1'b1;
                state_q    <= MOVE;
              end
            end else if (cur_q >= hi_q) begin
              // Park uses the best including this last measurement.
              vcm_step_q <= best_step_nxt;
              vcm_req_q  <= 1'b1;
              state_q    <= PARK;
            end else begin
              cur_q      <= fine_nxt;
              vcm_step_q <= fine_nxt[9:0];
              vcm_req_q  <= 1'b1;
              state_q    <= MOVE;
            end
          end
          FINE_INIT: begin
            cur_q      <= lo_calc;
            hi_q       <= hi_calc;
            scal_f_q   <= (SCAL_F == 8'd0) ? 8'd1 : SCAL_F;
            fine_q     <= 1'b1;
            vcm_step_q <= lo_calc[9:0];
            vcm_req_q  <= 1'b1;
            state_q    <= MOVE;
          end
          PARK: begin
            if (VCM_ACK) begin
              vcm_req_q <= 1'b0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              fine_q    <= 1'b0;
              state_q   <= FIN;
            end
          end
          FIN: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign VCM_STEP  = vcm_step_q;
  assign VCM_REQ   = vcm_req_q;
  assign BUSY      = busy_q;
  assign FINE      = fine_q;
  assign DONE      = done_q;
  assign BEST_STEP = best_step_q;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Directed bench for af_sweep_ctrl: nominal sweep, edge clamp, ties, ack back-pressure, abort, reset.
// Latency: n/a (testbench).
// Backpressure: VCM_ACK is driven by the directed steps below.
module tb_af_sweep_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, START, ABORT, VS, SHARP_VALID, VCM_ACK;
  logic [7:0]  SCAL, SCAL_F;
  logic [23:0] SHARP;
  logic [9:0]  VCM_STEP, BEST_STEP;
  logic        VCM_REQ, BUSY, FINE, DONE;

  int errors = 0;
  int checks = 0;
  int wr_q[$];
  int fn_q[$];
  int exp_q[$];
  int last_step = 0;
  int done_cnt = 0;
  int sharp_mode = 0;
  int env_cnt = 0;
  bit env_en = 1'b0;
  int n;
  int saved;

  af_sweep_ctrl dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .VS(VS),
    .SCAL(SCAL), .SCAL_F(SCAL_F), .SHARP(SHARP), .SHARP_VALID(SHARP_VALID),
    .VCM_STEP(VCM_STEP), .VCM_REQ(VCM_REQ), .VCM_ACK(VCM_ACK),
    .BUSY(BUSY), .FINE(FINE), .DONE(DONE), .BEST_STEP(BEST_STEP)
  );

  always #5 CLK = ~CLK;

  // Lens sharpness models: 0 = peak at 320, 1 = peak at 0, 2 = equal peaks at 128 and 192.
  function automatic int sharp_of(input int mode, input int s);
    if (mode == 0) return 2000 - ((s > 320) ? (s - 320) : (320 - s));
    if (mode == 1) return 2000 - s;
    return (s == 128 || s == 192) ? 5000 : 100;
  endfunction

  // Write log and DONE counter, sampled mid-cycle.
  always @(negedge CLK) begin
    if (VCM_REQ && VCM_ACK) begin
      wr_q.push_back(int'(VCM_STEP));
      fn_q.push_back(int'(FINE));
      last_step = int'(VCM_STEP);
    end
    if (DONE) done_cnt++;
  end

  // Sensor model: a frame every 6 cycles, sharpness strobe mid-frame.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (env_en) begin
        env_cnt++;
        VS          = (env_cnt % 6 == 0);
        SHARP_VALID = (env_cnt % 6 == 3);
        SHARP       = 24'(sharp_of(sharp_mode, last_step));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done_cnt != 0), 1);
  endtask

  // Coarse part is fixed for SCAL=64: 0..960 then 1023 (clamped 1024).
  task automatic build_exp(input int lo, input int hi, input int park);
    exp_q.delete();
    for (int s = 0; s <= 960; s += 64) exp_q.push_back(s);
    exp_q.push_back(1023);
    for (int s = lo; s <= hi; s += 4) exp_q.push_back(s);
    exp_q.push_back(park);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk({tag, "_wr"}, wr_q[i], exp_q[i]);
    if (fn_q.size() > 17) begin
      chk({tag, "_fine_lo"}, fn_q[16], 0);
      chk({tag, "_fine_hi"}, fn_q[17], 1);
    end
  endtask

  task automatic run_sweep(input int mode);
    sharp_mode = mode;
    wr_q.delete(); fn_q.delete();
    done_cnt = 0;
    env_en = 1'b1;
    VCM_ACK = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    SCAL = 8'd8;
    wait_done(4000);
    SCAL = 8'd64;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; VS = 1'b0; SHARP_VALID = 1'b0;
    VCM_ACK = 1'b0; SCAL = 8'd64; SCAL_F = 8'd4; SHARP = 24'd0;
    repeat (3) tick();
    chk("rst_req", 32'(VCM_REQ), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_fine", 32'(FINE), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_step", 32'(VCM_STEP), 0);
    chk("rst_best", 32'(BEST_STEP), 0);
    RESET = 1'b0;
    tick();

    // Nominal sweep, peak at 320 (SCAL changed to 8 mid-sweep must be ignored).
    run_sweep(0);
    build_exp(288, 352, 320);
    check_seq("nom");
    chk("nom_best", 32'(BEST_STEP), 320);
    repeat (3) tick();
    chk("nom_done_once", 32'(done_cnt), 1);
    chk("nom_busy_off", 32'(BUSY), 0);
    chk("nom_fine_off", 32'(FINE), 0);
    chk("nom_park_hold", 32'(VCM_STEP), 320);

    // Edge clamp, peak at 0.
    run_sweep(1);
    build_exp(0, 32, 0);
    check_seq("edge");
    chk("edge_best", 32'(BEST_STEP), 0);

    // Equal peaks: earliest wins.
    run_sweep(2);
    build_exp(96, 160, 128);
    check_seq("tie");
    chk("tie_best", 32'(BEST_STEP), 128);

    // Back-pressure: ack arrives in the 6th request cycle; VS edges during MOVE must not count.
    env_en = 1'b0; VS = 1'b0; SHARP_VALID = 1'b0; VCM_ACK = 1'b0;
    wr_q.delete(); fn_q.delete();
    repeat (2) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("bp_req_held", 32'(VCM_REQ), 1);
      chk("bp_step_stable", 32'(VCM_STEP), 0);
      VS = (i % 2 == 0);
      if (i == 5) VCM_ACK = 1'b1;
      tick();
    end
    chk("bp_req_drop", 32'(VCM_REQ), 0);
    VS = 1'b0;
    SHARP_VALID = 1'b1;
    repeat (20) tick();
    SHARP_VALID = 1'b0;
    chk("bp_no_early_settle", 32'(wr_q.size()), 1);
    chk("bp_still_busy", 32'(BUSY), 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("bp_abort_idle", 32'(BUSY), 0);

    // Abort during SETTLE of step 256.
    sharp_mode = 0;
    wr_q.delete(); fn_q.delete();
    done_cnt = 0;
    env_en = 1'b1;
    VCM_ACK = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (!(wr_q.size() > 0 && wr_q[$] == 256) && n < 2000) begin
      tick();
      n++;
    end
    chk("ab_reached_256", 32'(wr_q.size() > 0 && wr_q[$] == 256), 1);
    chk("ab_settling_req", 32'(VCM_REQ), 0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_busy", 32'(BUSY), 0);
    chk("ab_req", 32'(VCM_REQ), 0);
    chk("ab_done", 32'(DONE), 0);
    chk("ab_best_kept", 32'(BEST_STEP), 192);
    saved = wr_q.size();
    repeat (20) tick();
    chk("ab_no_done", 32'(done_cnt), 0);
    chk("ab_no_writes", 32'(wr_q.size()), 32'(saved));
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("ab_restart_req", 32'(VCM_REQ), 1);
    chk("ab_restart_step", 32'(VCM_STEP), 0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;

    // SCAL of 0 behaves as 1.
    SCAL = 8'd0;
    wr_q.delete(); fn_q.delete();
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (wr_q.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    chk("scal0_second", (wr_q.size() >= 2) ? 32'(wr_q[1]) : 32'hFFFF_FFFF, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    SCAL = 8'd64;

    // Reset while a write of 192 is pending.
    wr_q.delete(); fn_q.delete();
    VCM_ACK = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (!(wr_q.size() > 0 && wr_q[$] == 128) && n < 2000) begin
      tick();
      n++;
    end
    VCM_ACK = 1'b0;
    n = 0;
    while (!VCM_REQ && n < 200) begin
      tick();
      n++;
    end
    chk("rs_pending_step", 32'(VCM_STEP), 192);
    chk("rs_pending_best", 32'(BEST_STEP), 128);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rs_req", 32'(VCM_REQ), 0);
    chk("rs_busy", 32'(BUSY), 0);
    chk("rs_fine", 32'(FINE), 0);
    chk("rs_done", 32'(DONE), 0);
    chk("rs_step", 32'(VCM_STEP), 0);
    chk("rs_best", 32'(BEST_STEP), 0);
    VCM_ACK = 1'b1;
    saved = wr_q.size();
    repeat (12) tick();
    chk("idle_sv_busy", 32'(BUSY), 0);
    chk("idle_sv_best", 32'(BEST_STEP), 0);
    chk("idle_sv_writes", 32'(wr_q.size()), 32'(saved));

    // ABORT beats START in the same cycle.
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    chk("abst_busy", 32'(BUSY), 0);
    chk("abst_req", 32'(VCM_REQ), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
